// File: rtl/srt_div_r4.sv
// Radix-4 iterative divider: one quotient digit per cycle, with signed/unsigned mode,
// divide-by-zero and overflow flags, and results that hold until the next operation.
module srt_div_r4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;

    logic             sop_q, sop_d, sn_q, sn_d, sd_q, sd_d, dz_q, dz_d;
    logic [WIDTH-1:0] nabs_q, nabs_d, dabs_q, dabs_d, nraw_q, nraw_d;
    logic [WIDTH-1:0] nsh_q, nsh_d, qsh_q, qsh_d;
    // Partial remainder is always below |D|, so WIDTH bits hold it between digits.
    logic [WIDTH-1:0] p_q, p_d;

    logic [WIDTH+1:0] x, d1, d2, d3, dq;
    logic [1:0]       digit;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        sop_d       = sop_q;
        sn_d        = sn_q;
        sd_d        = sd_q;
        dz_d        = dz_q;
        nabs_d      = nabs_q;
        dabs_d      = dabs_q;
        nraw_d      = nraw_q;
        nsh_d       = nsh_q;
        qsh_d       = qsh_q;
        p_d         = p_q;

        x  = {p_q, nsh_q[WIDTH-1:WIDTH-2]};
        d1 = {2'b00, dabs_q};
        d2 = {1'b0, dabs_q, 1'b0};
        d3 = d1 + d2;
        if (x >= d3) begin
            digit = 2'd3;
            dq    = d3;
        end else if (x >= d2) begin
            digit = 2'd2;
            dq    = d2;
        end else if (x >= d1) begin
            digit = 2'd1;
            dq    = d1;
        end else begin
            digit = 2'd0;
            dq    = '0;
        end

        accept = start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            IDLE: ;
            LOAD: begin
                p_d     = '0;
                qsh_d   = '0;
                nsh_d   = nabs_q;
                count_d = '0;
                dz_d    = (dabs_q == '0);
                // A zero divisor still passes through FIX so the result registers load in one place.
                state_d = (dabs_q == '0) ? FIX : ITER;
            end
            ITER: begin
                p_d     = WIDTH'(x - dq);
                qsh_d   = {qsh_q[WIDTH-3:0], digit};
                nsh_d   = nsh_q << 2;
                count_d = count_q + 1'b1;
                if (count_q == CW'(ITERS - 1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = nraw_q;
                end else begin
                    quotient_d  = (sn_q ^ sd_q) ? neg_w(qsh_q) : qsh_q;
                    remainder_d = sn_q ? neg_w(p_q) : p_q;
                end
                dbz_d   = dz_q;
                ovf_d   = sop_q && sn_q && sd_q && (nabs_q == MIN_W) && (dabs_q == ONE_W);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sop_d   = signed_op;
            sn_d    = signed_op && dividend[WIDTH-1];
            sd_d    = signed_op && divisor[WIDTH-1];
            nabs_d  = abs_op(dividend, signed_op);
            dabs_d  = abs_op(divisor, signed_op);
            nraw_d  = dividend;
            state_d = LOAD;
        end

        ready_d = (state_d == IDLE) || (state_d == DONE);
        busy_d  = !ready_d;
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        sop_q  <= sop_d;
        sn_q   <= sn_d;
        sd_q   <= sd_d;
        dz_q   <= dz_d;
        nabs_q <= nabs_d;
        dabs_q <= dabs_d;
        nraw_q <= nraw_d;
        nsh_q  <= nsh_d;
        qsh_q  <= qsh_d;
        p_q    <= p_d;
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_srt_div_r4.sv
// Scoreboarded bench for srt_div_r4: directed cases and sweeps at WIDTH=8,
// plus a random sweep on a WIDTH=16 instance.
module tb_srt_div_r4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic start8, sop8, ready8, busy8, done8, dz8, ov8;
    logic [7:0] n8, d8, q8, r8;
    logic start16, sop16, ready16, busy16, done16, dz16, ov16;
    logic [15:0] n16, d16, q16, r16;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit dz;
        bit ov;
        int lat;
        int t0;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    srt_div_r4 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .signed_op(sop8),
        .dividend(n8), .divisor(d8), .ready(ready8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    srt_div_r4 #(.WIDTH(16)) u_dut16 (
        .clk(clk), .resetn(resetn), .start(start16), .signed_op(sop16),
        .dividend(n16), .divisor(d16), .ready(ready16), .busy(busy16), .done(done16),
        .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
    );

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input bit s, input longint unsigned n,
                                   input longint unsigned d);
        exp_t e;
        longint unsigned m = (64'd1 << w) - 64'd1;
        longint one = 1;
        longint sn, sd;
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.t0 = 0;
        e.lat = w / 2 + 2;
        if (d == 0) begin
            e.q = m;
            e.r = n;
            e.dz = 1'b1;
            e.lat = 2;
        end else if (!s) begin
            e.q = n / d;
            e.r = n % d;
        end else begin
            sn = longint'(n) - (n[w-1] ? (one << w) : 0);
            sd = longint'(d) - (d[w-1] ? (one << w) : 0);
            if (sn == -(one << (w - 1)) && sd == -1) begin
                e.q = n;
                e.r = 0;
                e.ov = 1'b1;
            end else begin
                e.q = longint'(sn / sd) & m;
                e.r = longint'(sn % sd) & m;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        if (resetn && done8) begin
            if (sb8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e = sb8.pop_front();
                check("q8", q8, e.q);
                check("r8", r8, e.r);
                check("dz8", dz8, e.dz);
                check("ov8", ov8, e.ov);
                check("lat8", cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (resetn && done16) begin
            if (sb16.size() == 0) check("unexpected_done16", 1, 0);
            else begin
                e = sb16.pop_front();
                check("q16", q16, e.q);
                check("r16", r16, e.r);
                check("dz16", dz16, e.dz);
                check("ov16", ov16, e.ov);
                check("lat16", cyc - e.t0, e.lat);
            end
        end
    end

    // Drives one request across the next rising edge, then scrambles the inputs.
    task automatic issue8(input bit s, input logic [7:0] n, input logic [7:0] d);
        exp_t e;
        e = model(8, s, n, d);
        start8 = 1'b1; sop8 = s; n8 = n; d8 = d;
        @(posedge clk); #1;
        start8 = 1'b0;
        sop8 = 1'($urandom); n8 = 8'($urandom); d8 = 8'($urandom);
        e.t0 = cyc;
        sb8.push_back(e);
    endtask

    task automatic wait8();
        int k = 0;
        do begin @(negedge clk); k++; end while (!done8 && k < 40);
        if (!done8) begin
            check("timeout8", 0, 1);
            sb8.delete();
        end
    endtask

    task automatic issue16(input bit s, input logic [15:0] n, input logic [15:0] d);
        exp_t e;
        e = model(16, s, n, d);
        start16 = 1'b1; sop16 = s; n16 = n; d16 = d;
        @(posedge clk); #1;
        start16 = 1'b0;
        sop16 = 1'($urandom); n16 = 16'($urandom); d16 = 16'($urandom);
        e.t0 = cyc;
        sb16.push_back(e);
    endtask

    task automatic wait16();
        int k = 0;
        do begin @(negedge clk); k++; end while (!done16 && k < 40);
        if (!done16) begin
            check("timeout16", 0, 1);
            sb16.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dl [16];
        logic [7:0] nv, dv;
        logic [15:0] n16v, d16v;
        bit sv;
        int t1;

        dl = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'h7F, 8'h80, 8'h81,
               8'hFE, 8'hFF, 8'd5, 8'd10, 8'd13, 8'd64, 8'd100, 8'd200};
        resetn = 1'b0;
        start8 = 1'b0; sop8 = 1'b0; n8 = '0; d8 = '0;
        start16 = 1'b0; sop16 = 1'b0; n16 = '0; d16 = '0;
        repeat (3) @(negedge clk);
        check("rst_q", q8, 0);
        check("rst_r", r8, 0);
        check("rst_done", done8, 0);
        check("rst_flags", {dz8, ov8}, 0);
        check("rst_ready", ready8, 1);
        check("rst_busy", busy8, 0);
        resetn = 1'b1;

        // Basic unsigned op with handshake visibility.
        @(negedge clk);
        issue8(1'b0, 8'd200, 8'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ready_low", ready8, 0);
            check("busy_high", busy8, 1);
        end
        wait8();
        check("t1_q", q8, 8'h1C);
        check("t1_r", r8, 8'd4);
        check("t1_ready", ready8, 1);

        @(negedge clk);
        issue8(1'b1, 8'hF9, 8'h02);
        wait8();
        check("t2a_q", q8, 8'hFD);
        check("t2a_r", r8, 8'hFF);
        @(negedge clk);
        issue8(1'b1, 8'h07, 8'hFE);
        wait8();
        check("t2b_q", q8, 8'hFD);
        check("t2b_r", r8, 8'h01);

        @(negedge clk);
        issue8(1'b0, 8'd13, 8'd0);
        wait8();
        check("t3_q", q8, 8'hFF);
        check("t3_r", r8, 8'h0D);
        check("t3_dz", dz8, 1);
        @(negedge clk);
        issue8(1'b1, 8'd13, 8'd0);
        wait8();
        @(negedge clk);
        issue8(1'b0, 8'd9, 8'd3);
        wait8();
        check("t3b_dz", dz8, 0);
        repeat (3) @(negedge clk);
        check("hold_q", q8, 8'd3);
        check("hold_r", r8, 8'd0);

        @(negedge clk);
        issue8(1'b1, 8'h80, 8'hFF);
        wait8();
        check("t4a_q", q8, 8'h80);
        check("t4a_ov", ov8, 1);
        @(negedge clk);
        issue8(1'b0, 8'h80, 8'hFF);
        wait8();
        check("t4b_r", r8, 8'h80);
        check("t4b_ov", ov8, 0);

        // Start reasserted mid-operation, then a start during DONE.
        @(negedge clk);
        issue8(1'b0, 8'd100, 8'd9);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; n8 = 8'd1; d8 = 8'd1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8();
        check("t5_q", q8, 8'd11);
        check("t5_r", r8, 8'd1);
        t1 = cyc;
        issue8(1'b0, 8'd50, 8'd5);
        wait8();
        check("b2b_gap", cyc - t1, 7);
        check("t5b_q", q8, 8'd10);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        issue8(1'b0, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("arst_q", q8, 0);
        check("arst_r", r8, 0);
        check("arst_ready", ready8, 1);
        check("arst_busy", busy8, 0);
        sb8.delete();
        repeat (3) @(negedge clk);
        check("arst_done", done8, 0);
        resetn = 1'b1;
        @(negedge clk);
        issue8(1'b0, 8'd255, 8'd16);
        wait8();
        check("t6_q", q8, 8'd15);
        check("t6_r", r8, 8'd15);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i <= 85; i++) begin
                nv = (i == 0) ? 8'd0 : 8'(3 * i - 1);
                for (int j = 0; j < 16; j++) begin
                    dv = (j >= 10 && ((i & 1) != 0)) ? 8'($urandom) : dl[j];
                    @(negedge clk);
                    issue8(s[0], nv, dv);
                    wait8();
                end
            end
        end

        for (int i = 0; i < 400; i++) begin
            sv = 1'($urandom);
            n16v = 16'($urandom);
            d16v = 16'($urandom);
            case (i % 16)
                3: d16v = 16'd0;
                5: d16v = 16'd1;
                7: begin n16v = 16'h8000; d16v = 16'hFFFF; end
                9: d16v = 16'hFFFF;
                11: d16v = 16'($urandom_range(1, 40));
                default: ;
            endcase
            @(negedge clk);
            issue16(sv, n16v, d16v);
            wait16();
        end

        repeat (2) @(negedge clk);
        check("sb8_empty", sb8.size(), 0);
        check("sb16_empty", sb16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
